// File: rtl/reduce_pkg.sv
// Shared constants and elaboration helpers for the pipelined N-input reducer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package reduce_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OR  = 2'b00;
    localparam mode_t MODE_AND = 2'b01;
    localparam mode_t MODE_XOR = 2'b10;
    localparam mode_t MODE_NOR = 2'b11;

    // Number of 4-input tree levels needed to cover n leaves (at least one).
    function automatic int clog4(input int n);
        int lvls;
        int cap;
        lvls = 1;
        cap  = 4;
        for (int i = 0; i < 8; i++) begin
            if (cap < n) begin
                cap  = cap * 4;
                lvls = lvls + 1;
            end
        end
        return lvls;
    endfunction

    // Number of group results produced by tree level lvl for a w-bit input.
    function automatic int groups_at(input int w, input int lvl);
        int n;
        n = w;
        for (int i = 0; i < 8; i++) begin
            if (i <= lvl) begin
                n = (n + 3) / 4;
            end
        end
        return n;
    endfunction

    // Bit offset of level lvl's results inside the flattened result vector.
    function automatic int offset(input int w, input int lvl);
        int o;
        o = 0;
        for (int k = 0; k < 8; k++) begin
            if (k < lvl) begin
                o = o + groups_at(w, k);
            end
        end
        return o;
    endfunction

    // Padding value that leaves a reduction unchanged; NOR reduces as OR internally.
    function automatic logic ident(input mode_t mode);
        return (mode == MODE_AND);
    endfunction

endpackage

// File: rtl/reduce4_stage_v.sv
// One registered 4-input reduce of a group; lanes beyond NUSED take the padding value.
// Latency: 1 cycle from i_en to o_f.
// Backpressure: none; the register holds its value whenever i_en is low.
module reduce4_stage_v
    import reduce_pkg::*;
#(
    parameter int NUSED = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  mode_t            i_mode,
    input  logic             i_pad,
    input  logic [NUSED-1:0] i_dat,
    output logic             o_f
);

    logic [3:0] grp;
    logic       red;
    logic       f_d;
    logic       f_q;

    // Fill missing lanes with the mode's identity so partial groups reduce correctly.
    for (genvar j = 0; j < 4; j++) begin : g_lane
        if (j < NUSED) begin : g_real
            assign grp[j] = i_dat[j];
        end else begin : g_pad
            assign grp[j] = i_pad;
        end
    end

    // Reduce the group; NOR is treated as OR, the inversion happens once at the tree root.
    always_comb begin
        red = 1'b0;
        case (i_mode)
            MODE_AND: red = &grp;
            MODE_XOR: red = ^grp;
            default:  red = |grp;
        endcase
        f_d = i_en ? red : f_q;
    end

    // Result register; only loads for valid samples so idle-cycle X never enters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            f_q <= 1'b0;
        end else begin
            f_q <= f_d;
        end
    end

    assign o_f = f_q;

endmodule

// File: rtl/reduce_n_pipe_v.sv
// Pipelined WIDTH-to-1 reducer (OR/AND/XOR/NOR per sample) with sticky any-one flag.
// Latency: LEVELS cycles from i_valid to o_valid, one sample per cycle.
// Backpressure: none; idle cycles travel as bubbles and o_f holds the last result.
module reduce_n_pipe_v
    import reduce_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    output logic             o_valid,
    output logic             o_f,
    output logic             o_sticky
);

    localparam int LEVELS = clog4(WIDTH);
    localparam int TOT    = offset(WIDTH, LEVELS);

    // All group results of all levels, level 0 first; the last bit is the tree root.
    logic [TOT-1:0]          res_flat;

    logic [LEVELS-1:0]       vld_d;
    logic [LEVELS-1:0]       vld_q;
    mode_t [LEVELS-1:0]      mode_d;
    mode_t [LEVELS-1:0]      mode_q;
    logic                    sticky_d;
    logic                    sticky_q;
    logic                    result;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int NIN     = (l == 0) ? WIDTH : groups_at(WIDTH, l - 1);
        localparam int NOUT    = groups_at(WIDTH, l);
        localparam int OFF_OUT = offset(WIDTH, l);

        logic [NIN-1:0] din;
        logic           en;
        mode_t          md;
        logic           pad;

        if (l == 0) begin : g_src
            assign din = i_data;
            assign en  = i_valid;
            assign md  = mode_t'(i_mode);
        end else begin : g_src
            assign din = res_flat[offset(WIDTH, l - 1) +: NIN];
            assign en  = vld_q[l-1];
            assign md  = mode_q[l-1];
        end

        assign pad = ident(md);

        for (genvar g = 0; g < NOUT; g++) begin : g_grp
            localparam int NU = ((NIN - 4 * g) >= 4) ? 4 : (NIN - 4 * g);

            reduce4_stage_v #(
                .NUSED (NU)
            ) u_stage (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_en    (en),
                .i_mode  (md),
                .i_pad   (pad),
                .i_dat   (din[4*g +: NU]),
                .o_f     (res_flat[OFF_OUT + g])
            );
        end
    end

    // Valid bits always shift; each level's mode loads alongside its data.
    always_comb begin
        vld_d     = '0;
        mode_d    = mode_q;
        vld_d[0]  = i_valid;
        if (i_valid) begin
            mode_d[0] = mode_t'(i_mode);
        end
        for (int l = 1; l < LEVELS; l++) begin
            vld_d[l] = vld_q[l-1];
            if (vld_q[l-1]) begin
                mode_d[l] = mode_q[l-1];
            end
        end
    end

    // Per-level valid and mode registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q  <= '0;
            mode_q <= '0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
        end
    end

    // Root result with the deferred NOR inversion.
    assign result = res_flat[TOT-1] ^ (mode_q[LEVELS-1] == MODE_NOR);

    // Sticky flag: a valid result arriving with clear overrides the clear.
    always_comb begin
        sticky_d = sticky_q;
        if (i_clr && vld_q[LEVELS-1]) begin
            sticky_d = result;
        end else if (i_clr) begin
            sticky_d = 1'b0;
        end else if (vld_q[LEVELS-1]) begin
            sticky_d = sticky_q | result;
        end
    end

    // Sticky register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign o_valid  = vld_q[LEVELS-1];
    assign o_f      = result;
    assign o_sticky = sticky_q;

endmodule

// File: tb/tb_reduce_n_pipe_v.sv
// Directed bench for reduce_n_pipe_v at WIDTH=16 and WIDTH=6 (padded tree).
// Latency: checks two-cycle result timing for both instances.
// Backpressure: exercises bubbles, hold and sticky clear priority.
module tb_reduce_n_pipe_v;

    logic        clk;
    logic        rst_n;

    logic        v16;
    logic [15:0] d16;
    logic [1:0]  m16;
    logic        c16;
    logic        ov16;
    logic        f16;
    logic        s16;

    logic        v6;
    logic [5:0]  d6;
    logic [1:0]  m6;
    logic        c6;
    logic        ov6;
    logic        f6;
    logic        s6;

    int n_checks;
    int n_fail;

    reduce_n_pipe_v #(.WIDTH(16)) u16 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (v16),
        .i_data   (d16),
        .i_mode   (m16),
        .i_clr    (c16),
        .o_valid  (ov16),
        .o_f      (f16),
        .o_sticky (s16)
    );

    reduce_n_pipe_v #(.WIDTH(6)) u6 (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (v6),
        .i_data   (d6),
        .i_mode   (m6),
        .i_clr    (c6),
        .o_valid  (ov6),
        .o_f      (f6),
        .o_sticky (s6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        v16 = 1'b0; d16 = 16'h0000; m16 = 2'b00; c16 = 1'b0;
        v6  = 1'b0; d6  = 6'b0;     m6  = 2'b00; c6  = 1'b0;

        // Reset state
        #12;
        chk("rst_ov16", ov16, 1'b0);
        chk("rst_f16",  f16,  1'b0);
        chk("rst_s16",  s16,  1'b0);
        chk("rst_ov6",  ov6,  1'b0);
        tick();
        rst_n = 1'b1;
        // X on data while idle must not reach o_f
        d16 = 16'hxxxx;
        tick();
        tick();
        tick();
        chk("idle_x_f16", f16, 1'b0);

        // OR walk
        v16 = 1'b1; m16 = 2'b00; d16 = 16'h0000;
        tick();
        chk("walk_lat_ov", ov16, 1'b0);
        d16 = 16'h0004;
        tick();
        chk("walk0_ov", ov16, 1'b1);
        chk("walk0_f",  f16,  1'b0);
        d16 = 16'h0040;
        tick();
        chk("walk1_ov", ov16, 1'b1);
        chk("walk1_f",  f16,  1'b1);
        d16 = 16'h8000;
        tick();
        chk("walk2_f",  f16,  1'b1);
        chk("walk2_s",  s16,  1'b1);
        // Reset mid-flight with a sample in the pipe
        d16 = 16'h0001;
        tick();
        chk("walk3_ov", ov16, 1'b1);
        chk("walk3_f",  f16,  1'b1);
        rst_n = 1'b0;
        v16 = 1'b0;
        #1;
        chk("mid_rst_ov", ov16, 1'b0);
        chk("mid_rst_f",  f16,  1'b0);
        chk("mid_rst_s",  s16,  1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ov0", ov16, 1'b0);
        tick();
        chk("post_rst_ov1", ov16, 1'b0);
        tick();
        chk("post_rst_ov2", ov16, 1'b0);

        // Mixed modes back-to-back
        v16 = 1'b1; m16 = 2'b01; d16 = 16'hFFFF;
        tick();
        m16 = 2'b01; d16 = 16'hFFFE;
        tick();
        chk("and_ffff_ov", ov16, 1'b1);
        chk("and_ffff_f",  f16,  1'b1);
        m16 = 2'b10; d16 = 16'h0007;
        tick();
        chk("and_fffe_f", f16, 1'b0);
        m16 = 2'b11; d16 = 16'h0000;
        tick();
        chk("xor_0007_f", f16, 1'b1);
        v16 = 1'b0;
        tick();
        chk("nor_0000_ov", ov16, 1'b1);
        chk("nor_0000_f",  f16,  1'b1);
        tick();
        chk("mix_end_ov", ov16, 1'b0);

        // Padding on the WIDTH=6 instance
        v6 = 1'b1; m6 = 2'b01; d6 = 6'b111111;
        tick();
        m6 = 2'b10; d6 = 6'b100001;
        tick();
        chk("pad_and_ov", ov6, 1'b1);
        chk("pad_and_f",  f6,  1'b1);
        m6 = 2'b00; d6 = 6'b000000;
        tick();
        chk("pad_xor_f", f6, 1'b0);
        m6 = 2'b11; d6 = 6'b000000;
        tick();
        chk("pad_or_f", f6, 1'b0);
        v6 = 1'b0;
        tick();
        chk("pad_nor_ov", ov6, 1'b1);
        chk("pad_nor_f",  f6,  1'b1);

        // Bubbles and hold
        v16 = 1'b1; m16 = 2'b00; d16 = 16'h0000;
        tick();
        d16 = 16'h0010;
        tick();
        chk("bub_pre_f", f16, 1'b0);
        v16 = 1'b0;
        tick();
        chk("bub_ov", ov16, 1'b1);
        chk("bub_f",  f16,  1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("bub_hold_ov%0d", i), ov16, 1'b0);
            chk($sformatf("bub_hold_f%0d", i),  f16,  1'b1);
        end

        // Sticky: clear, then results 0,1,0
        c16 = 1'b1;
        tick();
        chk("stk_clr0", s16, 1'b0);
        c16 = 1'b0;
        v16 = 1'b1; d16 = 16'h0000;
        tick();
        d16 = 16'h0001;
        tick();
        d16 = 16'h0000;
        tick();
        chk("stk_after0", s16, 1'b0);
        v16 = 1'b0;
        tick();
        chk("stk_after1", s16, 1'b1);
        tick();
        chk("stk_after2", s16, 1'b1);
        // Clear alone
        c16 = 1'b1;
        tick();
        chk("stk_clr_alone", s16, 1'b0);
        c16 = 1'b0;
        // Clear together with a valid result of 1
        v16 = 1'b1; d16 = 16'h0001;
        tick();
        v16 = 1'b0;
        tick();
        chk("stk_pre_ov", ov16, 1'b1);
        c16 = 1'b1;
        tick();
        chk("stk_clr_new1", s16, 1'b1);
        c16 = 1'b0;
        // Clear together with a valid result of 0
        v16 = 1'b1; d16 = 16'h0000;
        tick();
        v16 = 1'b0;
        tick();
        c16 = 1'b1;
        tick();
        chk("stk_clr_new0", s16, 1'b0);
        c16 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reduce_n_pipe_v.md
Name: reduce_n_pipe_v

Overview:
- Parametrised, pipelined successor to the fixed 4-input OR gate: reduces an N-bit input vector to one bit.
- Built as a tree of 4-input reduction stages with one register per tree level.
- Operation is selectable per sample: OR, AND, XOR or NOR.
- Carries a valid flag alongside the data, and keeps a sticky "any result was 1" flag with a synchronous clear.
- Serves as the generic reduction primitive for the combinational-circuits datapath (flag aggregation, parity, all-ones detect).

Parameters:
- WIDTH, 16, number of input bits (1..256).
- LEVELS, derived = max(1, ceil(log4(WIDTH))), number of pipeline stages. Local; not overridable.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  sample on i_data/i_mode is valid this cycle.
- i_data  in  WIDTH  vector to reduce.
- i_mode  in  2  operation: 00 OR, 01 AND, 10 XOR, 11 NOR.
- i_clr  in  1  synchronous clear of o_sticky.
- o_valid  out  1  o_f carries a new result this cycle.
- o_f  out  1  reduction result; holds the last result while o_valid is 0.
- o_sticky  out  1  OR of every result emitted since the last clear or reset.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - all stage data registers, stage valid bits and stage mode registers go to 0;
  - o_valid=0, o_f=0, o_sticky=0.
  - Release is synchronous to i_clk. No in-flight sample survives reset.
- Latency: a sample accepted at edge k appears with o_valid=1 after edge k+LEVELS-1, i.e. exactly LEVELS cycles after i_valid is asserted.
- Throughput: one sample per cycle, no backpressure. i_valid may be high every cycle.
- Stage 0 registers:
  - reduces i_data in groups of 4 bits, giving ceil(WIDTH/4) partial results;
  - captures i_mode and i_valid alongside them.
- Each later stage reduces the previous stage's partial results in groups of 4, using that stage's registered mode.
- Mode travels with its sample: back-to-back samples with different modes each use their own mode.
- Padding: leaves beyond WIDTH, and partial groups at any level, are filled with the identity value:
  - 0 for OR, XOR and NOR;
  - 1 for AND.
- NOR is computed internally as OR; the inversion is applied only at the final stage output.
- Stage data and mode registers load only when that stage's incoming valid is 1; otherwise they hold. This is why o_f holds its last result.
- Valid bits always shift, so a 0 propagates as a bubble.
- o_sticky, evaluated at each edge in priority order:
  1. if i_clr=1 and the final stage is producing a valid result: o_sticky <= that result (new data wins over clear);
  2. else if i_clr=1: o_sticky <= 0;
  3. else if a valid result is produced: o_sticky <= o_sticky | result;
  4. else: hold.
- WIDTH=1: LEVELS=1; the stage reduces a single bit plus padding.
  - OR/AND/XOR give o_f = i_data; NOR gives ~i_data.
- WIDTH an exact power of 4: no padding; all groups are full.
- X on i_data while i_valid=0 must not propagate to o_f.

Decomposition:
- Shared package/include file (reduce_pkg):
  - constants MODE_OR=2'b00, MODE_AND=2'b01, MODE_XOR=2'b10, MODE_NOR=2'b11;
  - function clog4(n) for computing LEVELS;
  - function ident(mode) returning the padding value.
- One sub-module, reduce4_stage_v:
  - a registered 4-input reduce of one group, with inputs for the mode and the padding value;
  - instantiated by generate loops, once per group per level.
- Top level holds the per-level valid/mode registers, the final NOR inversion and the sticky logic.

Test Plan:
- Reset mid-flight (WIDTH=16, LEVELS=2): i_valid=1 with i_data=16'h0001 in OR mode, assert i_rst_n=0 one cycle later -> o_valid, o_f and o_sticky all 0 immediately; no o_valid pulse after release.
- OR walk (WIDTH=16): 16'h0000, 16'h0004, 16'h0040, 16'h8000 on consecutive cycles -> o_valid high from cycle 2, o_f = 0, 1, 1, 1.
- AND/XOR/NOR in mixed modes, back-to-back (WIDTH=16):
  - AND 16'hFFFF -> 1;
  - AND 16'hFFFE -> 0;
  - XOR 16'h0007 -> 1;
  - NOR 16'h0000 -> 1;
  - each result arrives 2 cycles after its input, in order.
- Padding (WIDTH=6, LEVELS=2):
  - AND 6'b111111 -> 1;
  - XOR 6'b100001 -> 0;
  - OR 6'b000000 -> 0;
  - NOR 6'b000000 -> 1.
- Bubbles and hold (WIDTH=16): OR 16'h0010, then i_valid=0 for 3 cycles -> one o_valid pulse; o_f stays 1 throughout the bubbles.
- Sticky (WIDTH=16, OR mode):
  - results 0, 1, 0 -> o_sticky ends at 1;
  - i_clr alone -> o_sticky=0;
  - i_clr in the same cycle as a valid result of 1 -> o_sticky=1.
